// File: rtl/hazard_fwd_ctrl.sv
// Hazard / forwarding controller for an in-order pipeline. It shadows the destinations in flight
// after ID, raises the ID stall, and registers EXE-aligned forwarding selects.
module hazard_fwd_ctrl #(
  parameter int REG_AW = 4,
  parameter int DEPTH  = 3,
  parameter int FWD_EN = 1,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_freeze,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic              id_src1_used,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  output logic              stall,
  output logic [SEL_W-1:0]  exe_fwd_sel1,
  output logic [SEL_W-1:0]  exe_fwd_sel2,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_cnt_clr
);

  // The WB slot writes through the register file and never matches, so only
  // slots 0..DEPTH-2 are kept. Only slot0 needs its load flag (load-use check).
  localparam int TRK = DEPTH - 1;

  logic [TRK-1:0]             valid_q;
  logic [TRK-1:0]             wb_q;
  logic [TRK-1:0][REG_AW-1:0] dest_q;
  logic                       load0_q;

  logic [TRK-1:0]   hit1, hit2;
  logic             load_use;
  logic             issue;
  logic [SEL_W-1:0] sel1_d, sel2_d, sel1_q, sel2_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Lowest-numbered (youngest) matching slot j forwards from slot j+1 once the consumer is in EXE.
  function automatic logic [SEL_W-1:0] youngest(input logic [TRK-1:0] hits);
    logic [SEL_W-1:0] sel;
    sel = '0;
    for (int j = TRK - 1; j >= 0; j--) begin
      if (hits[j]) sel = SEL_W'(j + 1);
    end
    return sel;
  endfunction

  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int j = 0; j < TRK; j++) begin
      hit1[j] = id_src1_used && valid_q[j] && wb_q[j] && (dest_q[j] == id_src1);
      hit2[j] = id_two_src   && valid_q[j] && wb_q[j] && (dest_q[j] == id_src2);
    end
  end

  assign load_use = (hit1[0] || hit2[0]) && load0_q;

  always_comb begin
    stall = 1'b0;
    if (id_valid && !flush) begin
      if (FWD_EN != 0) stall = load_use;
      else             stall = |(hit1 | hit2);
    end
  end

  assign issue = id_valid && !stall && !flush;

  always_comb begin
    sel1_d = '0;
    sel2_d = '0;
    if (FWD_EN != 0 && issue) begin
      sel1_d = youngest(hit1);
      sel2_d = youngest(hit2);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_cnt_clr)              cnt_d = '0;
    else if (stall && cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      wb_q    <= '0;
      dest_q  <= '0;
      load0_q <= 1'b0;
      sel1_q  <= '0;
      sel2_q  <= '0;
      cnt_q   <= '0;
    end else if (!ext_freeze) begin
      valid_q[0] <= issue;
      wb_q[0]    <= issue && id_wb_en;
      dest_q[0]  <= issue ? id_dest : '0;
      load0_q    <= issue && id_mem_r_en;
      for (int k = 1; k < TRK; k++) begin
        valid_q[k] <= valid_q[k-1];
        wb_q[k]    <= wb_q[k-1];
        dest_q[k]  <= dest_q[k-1];
      end
      sel1_q <= sel1_d;
      sel2_q <= sel2_d;
      cnt_q  <= cnt_d;
    end
  end

  assign exe_fwd_sel1 = sel1_q;
  assign exe_fwd_sel2 = sel2_q;
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: a forwarding instance and a stall-only instance share stimulus and are
// checked against an instruction-level model of in-flight writers.
module tb_hazard_fwd_ctrl;

  localparam int DEPTH = 3;
  localparam int CNT_W = 4;

  logic       clk, rst, ext_freeze, flush, id_valid;
  logic [3:0] id_src1, id_src2, id_dest;
  logic       id_src1_used, id_two_src, id_wb_en, id_mem_r_en, stall_cnt_clr;

  logic       stall_f, stall_r;
  logic [1:0] sel1_f, sel2_f, sel1_r, sel2_r;
  logic [CNT_W-1:0] cnt_f, cnt_r;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_fwd_ctrl #(.REG_AW(4), .DEPTH(DEPTH), .FWD_EN(1), .SEL_W(2), .CNT_W(CNT_W)) u_fwd (
    .clk(clk), .rst(rst), .ext_freeze(ext_freeze), .flush(flush), .id_valid(id_valid),
    .id_src1(id_src1), .id_src1_used(id_src1_used), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .stall(stall_f),
    .exe_fwd_sel1(sel1_f), .exe_fwd_sel2(sel2_f), .stall_cnt(cnt_f), .stall_cnt_clr(stall_cnt_clr));

  hazard_fwd_ctrl #(.REG_AW(4), .DEPTH(DEPTH), .FWD_EN(0), .SEL_W(2), .CNT_W(CNT_W)) u_raw (
    .clk(clk), .rst(rst), .ext_freeze(ext_freeze), .flush(flush), .id_valid(id_valid),
    .id_src1(id_src1), .id_src1_used(id_src1_used), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .stall(stall_r),
    .exe_fwd_sel1(sel1_r), .exe_fwd_sel2(sel2_r), .stall_cnt(cnt_r), .stall_cnt_clr(stall_cnt_clr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per instance (0 = forwarding, 1 = stall-only), the instructions now in EXE..WB.
  typedef struct { bit v; bit wb; bit ld; int dst; } instr_t;
  instr_t m_pipe[2][DEPTH];
  int     m_sel1[2], m_sel2[2], m_cnt[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit writes(int i, int j, bit used, int src);
    return used && m_pipe[i][j].v && m_pipe[i][j].wb && m_pipe[i][j].dst == src;
  endfunction

  function automatic bit m_stall(int i);
    if (!id_valid || flush) return 1'b0;
    for (int j = 0; j < DEPTH - 1; j++) begin
      if (writes(i, j, id_src1_used, int'(id_src1)) || writes(i, j, id_two_src, int'(id_src2))) begin
        if (i == 1) return 1'b1;
        if (j == 0 && m_pipe[i][0].ld) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic int m_fwd(int i, bit used, int src);
    for (int j = 0; j < DEPTH - 1; j++)
      if (writes(i, j, used, src)) return j + 1;
    return 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < DEPTH; j++) m_pipe[i][j] = '{0, 0, 0, 0};
      m_sel1[i] = 0; m_sel2[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic m_clock();
    for (int i = 0; i < 2; i++) begin
      bit st, enter;
      st = m_stall(i);
      if (!ext_freeze) begin
        enter = id_valid && !st && !flush;
        m_sel1[i] = (i == 0 && enter) ? m_fwd(i, id_src1_used, int'(id_src1)) : 0;
        m_sel2[i] = (i == 0 && enter) ? m_fwd(i, id_two_src, int'(id_src2)) : 0;
        if (stall_cnt_clr) m_cnt[i] = 0;
        else if (st && m_cnt[i] < (1 << CNT_W) - 1) m_cnt[i]++;
        for (int j = DEPTH - 1; j > 0; j--) m_pipe[i][j] = m_pipe[i][j-1];
        if (enter) m_pipe[i][0] = '{1, id_wb_en, id_mem_r_en, int'(id_dest)};
        else       m_pipe[i][0] = '{0, 0, 0, 0};
      end
    end
  endtask

  task automatic check_regs();
    chk("sel1_f", 32'(sel1_f), 32'(m_sel1[0]));
    chk("sel2_f", 32'(sel2_f), 32'(m_sel2[0]));
    chk("cnt_f",  32'(cnt_f),  32'(m_cnt[0]));
    chk("sel1_r", 32'(sel1_r), 32'(m_sel1[1]));
    chk("sel2_r", 32'(sel2_r), 32'(m_sel2[1]));
    chk("cnt_r",  32'(cnt_r),  32'(m_cnt[1]));
  endtask

  // Inputs are set by the caller at posedge+1; stall is checked, then one edge is taken.
  task automatic cycle();
    #1;
    chk("stall_f", 32'(stall_f), 32'(m_stall(0)));
    chk("stall_r", 32'(stall_r), 32'(m_stall(1)));
    m_clock();
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic set_instr(input bit v, input int s1, input bit u1, input int s2, input bit two,
                           input int d, input bit wb, input bit ld);
    id_valid = v; id_src1 = 4'(s1); id_src1_used = u1; id_src2 = 4'(s2); id_two_src = two;
    id_dest = 4'(d); id_wb_en = wb; id_mem_r_en = ld;
  endtask

  task automatic nop();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    #1;
    chk("rst_stall_f", 32'(stall_f), 32'(m_stall(0)));
    chk("rst_stall_r", 32'(stall_r), 32'(m_stall(1)));
    check_regs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ext_freeze = 0; flush = 0; stall_cnt_clr = 0;
    nop();
    m_reset();
    #2;
    do_reset();

    // ADD R1 then SUB R2,R1,R3: forwarded from MEM, no stall.
    set_instr(1, 0, 0, 0, 0, 1, 1, 0); cycle();
    set_instr(1, 1, 1, 3, 1, 2, 1, 0);
    #1 chk("dir_addsub_stall", 32'(stall_f), 32'd0);
    cycle();
    chk("dir_addsub_sel1", 32'(sel1_f), 32'd1);
    nop(); cycle(); cycle(); cycle();

    // LDR R4 then ADD R5,R4,R4: one bubble, then both operands from WB.
    set_instr(1, 0, 0, 0, 0, 4, 1, 1); cycle();
    set_instr(1, 4, 1, 4, 1, 5, 1, 0);
    #1 chk("dir_ldu_stall", 32'(stall_f), 32'd1);
    cycle();
    #1 chk("dir_ldu_stall2", 32'(stall_f), 32'd0);
    cycle();
    chk("dir_ldu_sel1", 32'(sel1_f), 32'd2);
    chk("dir_ldu_sel2", 32'(sel2_f), 32'd2);
    nop(); cycle(); cycle(); cycle();

    // ADD R1, NOP, ORR R6,R1 on the stall-only instance.
    set_instr(1, 0, 0, 0, 0, 1, 1, 0); cycle();
    nop(); cycle();
    set_instr(1, 1, 1, 0, 0, 6, 1, 0);
    #1 chk("dir_raw_stall", 32'(stall_r), 32'd1);
    cycle();
    #1 chk("dir_raw_go", 32'(stall_r), 32'd0);
    cycle();
    nop(); cycle(); cycle(); cycle();

    // Load-use with flush: no stall, bubble, selects 0.
    set_instr(1, 0, 0, 0, 0, 4, 1, 1); cycle();
    set_instr(1, 4, 1, 0, 0, 7, 1, 0); flush = 1;
    #1 chk("dir_flush_stall", 32'(stall_f), 32'd0);
    cycle();
    chk("dir_flush_sel1", 32'(sel1_f), 32'd0);
    flush = 0; nop(); cycle(); cycle(); cycle();

    // Freeze 5 cycles during a load-use stall, then resume.
    set_instr(1, 0, 0, 0, 0, 4, 1, 1); cycle();
    set_instr(1, 4, 1, 0, 0, 7, 1, 0);
    ext_freeze = 1;
    repeat (5) cycle();
    ext_freeze = 0;
    cycle(); cycle();
    nop(); cycle(); cycle(); cycle();

    // Saturation: 20 load-use stalls with a 4-bit counter, then clear.
    stall_cnt_clr = 1; cycle(); stall_cnt_clr = 0;
    for (int p = 0; p < 20; p++) begin
      set_instr(1, 0, 0, 0, 0, 4, 1, 1); cycle();
      set_instr(1, 4, 1, 0, 0, 5, 1, 0); cycle();
    end
    chk("dir_cnt_sat", 32'(cnt_f), 32'd15);
    stall_cnt_clr = 1; nop(); cycle(); stall_cnt_clr = 0;
    chk("dir_cnt_clr", 32'(cnt_f), 32'd0);

    // Reset in the middle of a stall.
    set_instr(1, 0, 0, 0, 0, 4, 1, 1); cycle();
    set_instr(1, 4, 1, 4, 1, 5, 1, 0);
    #1 chk("dir_pre_rst_stall", 32'(stall_f), 32'd1);
    rst = 1;
    #1;
    chk("dir_rst_stall", 32'(stall_f), 32'd0);
    chk("dir_rst_sel1", 32'(sel1_f), 32'd0);
    do_reset();

    // Randomized traffic over a small register set to provoke hazards.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        set_instr($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                  ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3), $urandom_range(0, 1),
                  ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        flush         = ($urandom_range(0, 9) == 0);
        ext_freeze    = ($urandom_range(0, 9) == 0);
        stall_cnt_clr = ($urandom_range(0, 29) == 0);
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
